// File: rtl/fsm_trace_sequencer.sv
// fsm_trace_sequencer
//   Schedules serial input traces onto a bank of three candidate FSM
//   implementations (A, B, C) that share one input bit and one reset.
//   A trace is accepted through a valid/ready handshake. The sequencer then
//   resets the bank for one cycle and shifts the trace in LSB first, one bit
//   per cycle. It captures the three FSM outputs every cycle and reports the
//   captured vectors, a mismatch flag and a saturating mismatch count.
//
//   Optional build macro: FSM_SEQ_DIVERGE_IDX_EN adds o_div_idx/o_div_found,
//   which report the first apply cycle in which the bank outputs disagreed.
//
// Ports
//   i_clk            system clock, all logic on posedge
//   i_rst            synchronous active-high reset
//   i_trace          trace to apply, bit 0 first
//   i_trace_valid    trace is valid (held by the source until accepted)
//   o_trace_ready    sequencer can accept a trace (IDLE only)
//   o_fsm_rst        reset to the FSM bank
//   o_fsm_in         serial input to the FSM bank
//   i_out_a/b/c      FSM bank outputs, sampled during APPLY only
//   o_res_valid      one-cycle result strobe
//   o_res_a/b/c      captured outputs, bit j sampled in apply cycle j
//   o_res_mismatch   captured vectors are not all equal
//   o_mismatch_cnt   saturating count of mismatching traces since reset
//   o_busy           state is not IDLE
//   o_div_idx        (macro) lowest disagreeing apply cycle, TRACE_W if none
//   o_div_found      (macro) a disagreeing apply cycle exists
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for a trace; ready except in the cycle after reset
//   S_RST    | one-cycle reset pulse to the FSM bank, capture cleared
//   S_APPLY  | TRACE_W cycles driving trace bits, capturing bank outputs
//   S_REPORT | one-cycle result strobe, mismatch counter update

module fsm_trace_sequencer #(
  parameter int TRACE_W = 7,
  parameter int CNT_W   = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [TRACE_W-1:0]           i_trace,
  input  logic                         i_trace_valid,
  output logic                         o_trace_ready,
  output logic                         o_fsm_rst,
  output logic                         o_fsm_in,
  input  logic                         i_out_a,
  input  logic                         i_out_b,
  input  logic                         i_out_c,
  output logic                         o_res_valid,
  output logic [TRACE_W-1:0]           o_res_a,
  output logic [TRACE_W-1:0]           o_res_b,
  output logic [TRACE_W-1:0]           o_res_c,
  output logic                         o_res_mismatch,
  output logic [CNT_W-1:0]             o_mismatch_cnt,
  output logic                         o_busy
`ifdef FSM_SEQ_DIVERGE_IDX_EN
  ,
  output logic [$clog2(TRACE_W+1)-1:0] o_div_idx,
  output logic                         o_div_found
`endif
);

  localparam int IDX_W = $clog2(TRACE_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RST    = 2'd1,
    S_APPLY  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_rst_q;
  logic                 w_accept;
  logic                 w_last;
  logic [TRACE_W-1:0]   r_shift;
  logic [IDX_W-1:0]     r_idx;
  logic [TRACE_W-1:0]   r_cap_a, r_cap_b, r_cap_c;
  logic [TRACE_W-1:0]   w_cap_a, w_cap_b, w_cap_c;
  logic [TRACE_W-1:0]   r_res_a, r_res_b, r_res_c;
  logic                 r_res_mismatch;
  logic [CNT_W-1:0]     r_cnt;

  assign w_last  = (r_idx == IDX_W'(TRACE_W - 1));
  // Capture registers are cleared in S_RST, so OR-ing in the current bit is
  // equivalent to writing bit r_idx.
  assign w_cap_a = r_cap_a | (TRACE_W'(i_out_a) << r_idx);
  assign w_cap_b = r_cap_b | (TRACE_W'(i_out_b) << r_idx);
  assign w_cap_c = r_cap_c | (TRACE_W'(i_out_c) << r_idx);

  assign o_res_a        = r_res_a;
  assign o_res_b        = r_res_b;
  assign o_res_c        = r_res_c;
  assign o_res_mismatch = r_res_mismatch;
  assign o_mismatch_cnt = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Keeps the bank in reset (and the handshake closed) for the first cycle
  // after reset is released.
  always_ff @(posedge i_clk) begin
    r_rst_q <= i_rst;
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    o_trace_ready = 1'b0;
    o_fsm_rst     = i_rst | r_rst_q;
    o_fsm_in      = 1'b0;
    o_res_valid   = 1'b0;
    o_busy        = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_IDLE: begin
          o_trace_ready = ~r_rst_q;
          if (i_trace_valid && !r_rst_q) begin
            w_accept     = 1'b1;
            w_state_next = S_RST;
          end
        end
        S_RST: begin
          o_busy       = 1'b1;
          o_fsm_rst    = 1'b1;
          w_state_next = S_APPLY;
        end
        S_APPLY: begin
          o_busy   = 1'b1;
          o_fsm_in = r_shift[0];
          if (w_last) begin
            w_state_next = S_REPORT;
          end
        end
        S_REPORT: begin
          o_busy       = 1'b1;
          o_res_valid  = 1'b1;
          w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift        <= '0;
      r_idx          <= '0;
      r_cap_a        <= '0;
      r_cap_b        <= '0;
      r_cap_c        <= '0;
      r_res_a        <= '0;
      r_res_b        <= '0;
      r_res_c        <= '0;
      r_res_mismatch <= 1'b0;
      r_cnt          <= '0;
    end else begin
      if (w_accept) begin
        r_shift <= i_trace;
      end
      if (r_state == S_RST) begin
        r_idx   <= '0;
        r_cap_a <= '0;
        r_cap_b <= '0;
        r_cap_c <= '0;
      end
      if (r_state == S_APPLY) begin
        r_shift <= r_shift >> 1;
        r_idx   <= r_idx + IDX_W'(1);
        r_cap_a <= w_cap_a;
        r_cap_b <= w_cap_b;
        r_cap_c <= w_cap_c;
        // Results load on the last apply edge so they are valid during
        // S_REPORT and stay put while the next trace is captured.
        if (w_last) begin
          r_res_a        <= w_cap_a;
          r_res_b        <= w_cap_b;
          r_res_c        <= w_cap_c;
          r_res_mismatch <= (w_cap_a != w_cap_b) || (w_cap_b != w_cap_c);
        end
      end
      if ((r_state == S_REPORT) && r_res_mismatch && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef FSM_SEQ_DIVERGE_IDX_EN
  logic             r_div_found_cap;
  logic [IDX_W-1:0] r_div_idx_cap;
  logic [IDX_W-1:0] r_div_idx;
  logic             r_div_found;
  logic             w_disagree;

  assign w_disagree  = (i_out_a != i_out_b) || (i_out_b != i_out_c);
  assign o_div_idx   = r_div_idx;
  assign o_div_found = r_div_found;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_found_cap <= 1'b0;
      r_div_idx_cap   <= '0;
      r_div_idx       <= '0;
      r_div_found     <= 1'b0;
    end else begin
      if (r_state == S_RST) begin
        r_div_found_cap <= 1'b0;
        r_div_idx_cap   <= '0;
      end
      if (r_state == S_APPLY) begin
        if (w_disagree && !r_div_found_cap) begin
          r_div_found_cap <= 1'b1;
          r_div_idx_cap   <= r_idx;
        end
        if (w_last) begin
          r_div_found <= r_div_found_cap | w_disagree;
          if (r_div_found_cap) begin
            r_div_idx <= r_div_idx_cap;
          end else if (w_disagree) begin
            r_div_idx <= r_idx;
          end else begin
            r_div_idx <= IDX_W'(TRACE_W);
          end
        end
      end
    end
  end
`endif

endmodule
